wt_dcache_repl: RTL and testbench

- Parametrised recency-stack replacement unit for the write-through L1 dcache; successor to the fixed 4-way predictor-LRU.
- Per set, keeps an ordered permutation of way indices (position 0 = LRU, position NUM_WAYS-1 = MRU).
- Supplies the victim way to the miss unit, preferring invalid ways.
- Updates recency on hits and refills; refills insert at a predictor-selected depth. Flush is a sequenced set walk.

---
 rtl/wt_dcache_repl.sv | 211 +++++++++++++++++++++
 tb/tb_wt_dcache_repl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_repl.sv
// wt_dcache_repl: per-set recency-stack replacement for the write-through L1 dcache.
// Each set holds a permutation of way indices (position 0 = LRU, NUM_WAYS-1 = MRU).
// Victim selection prefers invalid ways. Hits promote to MRU. Refills insert at a
// depth chosen by the reuse predictor. A flush walks every set back to identity.

// Permutation checker for rows written by hit/fill updates (walk writes identity).
module wt_dcache_repl_chk #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = 2
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  input logic                      hit_we_i,
  input logic [NUM_WAYS*WAY_W-1:0] hit_row_i,
  input logic                      fill_we_i,
  input logic [NUM_WAYS*WAY_W-1:0] fill_row_i
);

  function automatic logic is_perm(input logic [NUM_WAYS*WAY_W-1:0] row);
    logic           ok_v;
    logic [WAY_W:0] cnt_v;
    ok_v = 1'b1;
    for (int w = 0; w < NUM_WAYS; w++) begin
      cnt_v = {(WAY_W+1){1'b0}};
      for (int p = 0; p < NUM_WAYS; p++) begin
        cnt_v = cnt_v + {{WAY_W{1'b0}}, (row[p*WAY_W +: WAY_W] == WAY_W'(w))};
      end
      ok_v = ok_v & (cnt_v == {{WAY_W{1'b0}}, 1'b1});
    end
    return ok_v;
  endfunction

  hit_row_is_perm: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hit_we_i |-> is_perm(hit_row_i));

  fill_row_is_perm: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fill_we_i |-> is_perm(fill_row_i));

endmodule

module wt_dcache_repl #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 4,
  parameter int PRED_W   = 2,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                busy_o,
  input  logic                hit_i,
  input  logic [IDX_W-1:0]    hit_idx_i,
  input  logic [WAY_W-1:0]    hit_way_i,
  input  logic                fill_i,
  input  logic [IDX_W-1:0]    fill_idx_i,
  input  logic [WAY_W-1:0]    fill_way_i,
  input  logic [PRED_W-1:0]   pred_i,
  input  logic [IDX_W-1:0]    query_idx_i,
  input  logic [NUM_WAYS-1:0] valid_ways_i,
  output logic [WAY_W-1:0]    victim_way_o
);

  localparam int PMAX  = (1 << PRED_W) - 1;
  localparam int SUM_W = WAY_W + PRED_W;

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] row_t;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WALK = 1'b1} state_e;

  row_t             stack_r [NUM_SETS];
  state_e           state_r, state_nxt_s;
  logic [IDX_W-1:0] cnt_r, cnt_nxt_s;
  row_t             hit_row_nxt_s, fill_row_nxt_s;
  logic             hit_en_s, fill_en_s, walk_en_s;
  logic [WAY_W-1:0] ins_s, victim_s;

  function automatic row_t ident_row();
    row_t r;
    for (int k = 0; k < NUM_WAYS; k++) r[k] = WAY_W'(k);
    return r;
  endfunction

  // Remove 'way' from its slot, close the gap, place it at MRU.
  function automatic row_t hit_row(input row_t row, input logic [WAY_W-1:0] way);
    row_t r;
    int   h, s;
    h = NUM_WAYS - 1;
    for (int p = 0; p < NUM_WAYS; p++) if (row[p] == way) h = p;
    for (int p = 0; p < NUM_WAYS; p++) begin
      s    = (p >= h && p < NUM_WAYS - 1) ? p + 1 : p;
      r[p] = (p == NUM_WAYS - 1) ? way : row[s];
    end
    return r;
  endfunction

  // Move 'way' from its slot f to slot ins, shifting the entries in between.
  function automatic row_t fill_row(input row_t row, input logic [WAY_W-1:0] way,
                                    input logic [WAY_W-1:0] ins_v);
    row_t r;
    int   f, ins, s;
    f   = 0;
    ins = int'(ins_v);
    for (int p = 0; p < NUM_WAYS; p++) if (row[p] == way) f = p;
    for (int p = 0; p < NUM_WAYS; p++) begin
      s = p;
      if (ins > f && p >= f && p < ins) s = p + 1;
      else if (ins < f && p > ins && p <= f) s = p - 1;
      else s = p;
      r[p] = (p == ins) ? way : row[s];
    end
    return r;
  endfunction

  // Predictor to insertion depth: high reuse lands at MRU, dead-on-arrival at LRU.
  function automatic logic [WAY_W-1:0] ins_pos(input logic [PRED_W-1:0] pred);
    logic [SUM_W-1:0] prod, quo;
    prod = SUM_W'(pred) * SUM_W'(NUM_WAYS - 1);
    quo  = prod / SUM_W'(PMAX);
    return WAY_W'(SUM_W'(NUM_WAYS - 1) - quo);
  endfunction

  // Candidate rows and write enables; a same-set fill overrides the hit.
  always_comb begin
    ins_s          = ins_pos(pred_i);
    hit_row_nxt_s  = hit_row(stack_r[hit_idx_i], hit_way_i);
    fill_row_nxt_s = fill_row(stack_r[fill_idx_i], fill_way_i, ins_s);
    walk_en_s      = (state_r == ST_WALK);
    fill_en_s      = fill_i & ~walk_en_s;
    hit_en_s       = hit_i & ~walk_en_s & ~(fill_i & (fill_idx_i == hit_idx_i));
  end

  // Victim: lowest invalid way, otherwise the LRU entry of the queried set.
  always_comb begin
    victim_s = stack_r[query_idx_i][0];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      victim_s = valid_ways_i[w] ? victim_s : WAY_W'(w);
    end
  end

  assign victim_way_o = victim_s;
  assign busy_o       = (state_r == ST_WALK);

  // Flush walk next-state: restart on a new flush, leave after the last set.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (flush_i) begin
          state_nxt_s = ST_WALK;
          cnt_nxt_s   = {IDX_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_WALK: begin
        if (flush_i) begin
          state_nxt_s = ST_WALK;
          cnt_nxt_s   = {IDX_W{1'b0}};
        end else if (cnt_r == IDX_W'(NUM_SETS - 1)) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {IDX_W{1'b0}};
        end else begin
          state_nxt_s = ST_WALK;
          cnt_nxt_s   = cnt_r + IDX_W'(1'b1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Flush FSM state and walk counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      cnt_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Recency stacks: identity on reset/walk, otherwise hit and fill updates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) stack_r[s] <= ident_row();
    end else if (walk_en_s) begin
      stack_r[cnt_r] <= ident_row();
    end else begin
      if (fill_en_s) stack_r[fill_idx_i] <= fill_row_nxt_s;
      if (hit_en_s)  stack_r[hit_idx_i]  <= hit_row_nxt_s;
    end
  end

  wt_dcache_repl_chk #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .hit_we_i   (hit_en_s),
    .hit_row_i  (hit_row_nxt_s),
    .fill_we_i  (fill_en_s),
    .fill_row_i (fill_row_nxt_s)
  );

endmodule

// File: tb/tb_wt_dcache_repl.sv
// Self-checking bench for wt_dcache_repl: a 256x4 instance and an 8-way instance,
// each against a queue-based recency model; rows are read back through the victim
// port by hitting the LRU way NUM_WAYS times, which leaves the stack unchanged.
module tb_wt_dcache_repl;

  logic       clk = 1'b0;
  logic       rst_n, rst8_n;
  // 4-way instance
  logic       flush, busy, hit, fill;
  logic [7:0] hit_idx, fill_idx, q_idx;
  logic [1:0] hit_way, fill_way, pred, victim;
  logic [3:0] valid;
  // 8-way instance
  logic       flush8, busy8, hit8, fill8;
  logic [1:0] hit_idx8, fill_idx8, q_idx8;
  logic [2:0] hit_way8, fill_way8, pred8, victim8;
  logic [7:0] valid8;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m4 [256][4];
  int m8 [4][8];

  always #5 clk = ~clk;

  wt_dcache_repl #(.NUM_SETS(256), .NUM_WAYS(4), .PRED_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .busy_o(busy),
    .hit_i(hit), .hit_idx_i(hit_idx), .hit_way_i(hit_way),
    .fill_i(fill), .fill_idx_i(fill_idx), .fill_way_i(fill_way), .pred_i(pred),
    .query_idx_i(q_idx), .valid_ways_i(valid), .victim_way_o(victim)
  );

  wt_dcache_repl #(.NUM_SETS(4), .NUM_WAYS(8), .PRED_W(3)) dut8 (
    .clk_i(clk), .rst_ni(rst8_n), .flush_i(flush8), .busy_o(busy8),
    .hit_i(hit8), .hit_idx_i(hit_idx8), .hit_way_i(hit_way8),
    .fill_i(fill8), .fill_idx_i(fill_idx8), .fill_way_i(fill_way8), .pred_i(pred8),
    .query_idx_i(q_idx8), .valid_ways_i(valid8), .victim_way_o(victim8)
  );

  task automatic mdl_ident(input bit big, input int set);
    if (big) for (int k = 0; k < 8; k++) m8[set][k] = k;
    else     for (int k = 0; k < 4; k++) m4[set][k] = k;
  endtask

  // Reference update: pull the way out of the list, re-insert at MRU or at the fill depth.
  task automatic mdl_update(input bit big, input int set, input int way,
                            input bit is_fill, input int p);
    int q[$];
    int n, pmax, ins, pos;
    n    = big ? 8 : 4;
    pmax = big ? 7 : 3;
    for (int k = 0; k < n; k++) q.push_back(big ? m8[set][k] : m4[set][k]);
    pos = 0;
    for (int k = 0; k < n; k++) if (q[k] == way) pos = k;
    q.delete(pos);
    if (is_fill) begin
      ins = (n - 1) - (p * (n - 1)) / pmax;
      q.insert(ins, way);
    end else begin
      q.push_back(way);
    end
    for (int k = 0; k < n; k++) begin
      if (big) m8[set][k] = q[k];
      else     m4[set][k] = q[k];
    end
  endtask

  task automatic drive4(input bit h, input int hidx, input int hway,
                        input bit f, input int fidx, input int fway, input int p);
    @(negedge clk);
    hit = h; hit_idx = 8'(hidx); hit_way = 2'(hway);
    fill = f; fill_idx = 8'(fidx); fill_way = 2'(fway); pred = 2'(p);
    if (f) mdl_update(1'b0, fidx, fway, 1'b1, p);
    if (h && !(f && fidx == hidx)) mdl_update(1'b0, hidx, hway, 1'b0, 0);
    @(posedge clk); #1;
    hit = 1'b0; fill = 1'b0;
  endtask

  task automatic drive8(input bit h, input int hidx, input int hway,
                        input bit f, input int fidx, input int fway, input int p);
    @(negedge clk);
    hit8 = h; hit_idx8 = 2'(hidx); hit_way8 = 3'(hway);
    fill8 = f; fill_idx8 = 2'(fidx); fill_way8 = 3'(fway); pred8 = 3'(p);
    if (f) mdl_update(1'b1, fidx, fway, 1'b1, p);
    if (h && !(f && fidx == hidx)) mdl_update(1'b1, hidx, hway, 1'b0, 0);
    @(posedge clk); #1;
    hit8 = 1'b0; fill8 = 1'b0;
  endtask

  // Observe a full row: read the LRU way, hit it, repeat NUM_WAYS times.
  task automatic read_row(input bit big, input int set, output logic [7:0] obs [8]);
    int n;
    n = big ? 8 : 4;
    for (int k = 0; k < 8; k++) obs[k] = 8'd0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (big) begin
        q_idx8 = 2'(set); valid8 = 8'hFF; #1;
        obs[k] = 8'(victim8);
        hit8 = 1'b1; hit_idx8 = 2'(set); hit_way8 = victim8;
      end else begin
        q_idx = 8'(set); valid = 4'hF; #1;
        obs[k] = 8'(victim);
        hit = 1'b1; hit_idx = 8'(set); hit_way = victim;
      end
      @(posedge clk); #1;
      hit = 1'b0; hit8 = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] obs [8];
    int e;
    @(negedge clk);
    q_idx = 8'd5; valid = 4'hF; q_idx8 = 2'd0; valid8 = 8'hFF; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %0b exp 0", busy8); end
    exp_q.push_back(m4[5][0]);
    e = exp_q.pop_front();
    checks++; if (victim !== 2'(e)) begin errors++; $display("FAIL reset_victim got %0d exp %0d", victim, e); end
    exp_q.push_back(m8[0][0]);
    e = exp_q.pop_front();
    checks++; if (victim8 !== 3'(e)) begin errors++; $display("FAIL reset_victim8 got %0d exp %0d", victim8, e); end
    for (int k = 0; k < 4; k++) exp_q.push_back(m4[5][k]);
    read_row(1'b0, 5, obs);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== 8'(e)) begin errors++; $display("FAIL reset_row pos%0d got %0d exp %0d", k, obs[k], e); end
    end
  endtask

  task automatic test_hit();
    logic [7:0] obs [8];
    int e;
    drive4(1'b1, 5, 0, 1'b0, 0, 0, 0);
    @(negedge clk); q_idx = 8'd5; valid = 4'hF; #1;
    exp_q.push_back(m4[5][0]);
    e = exp_q.pop_front(); checks++;
    if (victim !== 2'(e)) begin errors++; $display("FAIL hit_victim got %0d exp %0d", victim, e); end
    for (int k = 0; k < 4; k++) exp_q.push_back(m4[5][k]);
    read_row(1'b0, 5, obs);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== 8'(e)) begin errors++; $display("FAIL hit_row pos%0d got %0d exp %0d", k, obs[k], e); end
    end
  endtask

  task automatic test_fill();
    logic [7:0] obs [8];
    int e;
    int fw [3] = '{0, 0, 1};
    int fp [3] = '{3, 1, 0};
    for (int i = 0; i < 3; i++) begin
      drive4(1'b0, 0, 0, 1'b1, 7, fw[i], fp[i]);
      @(negedge clk); q_idx = 8'd7; valid = 4'hF; #1;
      exp_q.push_back(m4[7][0]);
      e = exp_q.pop_front(); checks++;
      if (victim !== 2'(e)) begin errors++; $display("FAIL fill_victim step%0d got %0d exp %0d", i, victim, e); end
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(m4[7][k]);
    read_row(1'b0, 7, obs);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== 8'(e)) begin errors++; $display("FAIL fill_row pos%0d got %0d exp %0d", k, obs[k], e); end
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] obs [8];
    int e;
    int sets [3] = '{9, 3, 4};
    drive4(1'b1, 9, 2, 1'b1, 9, 2, 3);
    drive4(1'b1, 3, 1, 1'b1, 4, 0, 0);
    foreach (sets[i]) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(m4[sets[i]][k]);
      read_row(1'b0, sets[i], obs);
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front(); checks++;
        if (obs[k] !== 8'(e)) begin errors++; $display("FAIL same_cycle_row set%0d pos%0d got %0d exp %0d", sets[i], k, obs[k], e); end
      end
    end
    // query in the update cycle sees the old stack, the next cycle sees the new one
    @(negedge clk);
    q_idx = 8'd11; valid = 4'hF; hit = 1'b1; hit_idx = 8'd11; hit_way = 2'd0; #1;
    exp_q.push_back(m4[11][0]);
    mdl_update(1'b0, 11, 0, 1'b0, 0);
    e = exp_q.pop_front(); checks++;
    if (victim !== 2'(e)) begin errors++; $display("FAIL query_old_state got %0d exp %0d", victim, e); end
    exp_q.push_back(m4[11][0]);
    @(posedge clk); #1; hit = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (victim !== 2'(e)) begin errors++; $display("FAIL query_new_state got %0d exp %0d", victim, e); end
  endtask

  task automatic test_valid_mask();
    int e;
    logic [3:0] m;
    logic [3:0] masks [4] = '{4'b1011, 4'b0000, 4'b1111, 4'b0111};
    for (int i = 0; i < 12; i++) begin
      m = (i < 4) ? masks[i] : 4'($urandom_range(0, 15));
      @(negedge clk); q_idx = 8'd7; valid = m;
      e = m4[7][0];
      for (int w = 3; w >= 0; w--) if (!m[w]) e = w;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front(); checks++;
      if (victim !== 2'(e)) begin errors++; $display("FAIL valid_mask %b got %0d exp %0d", m, victim, e); end
    end
  endtask

  task automatic test_random();
    logic [7:0] obs [8];
    int e;
    for (int i = 0; i < 200; i++)
      drive4(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3),
             $urandom_range(0, 3));
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(m4[s][k]);
      read_row(1'b0, s, obs);
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front(); checks++;
        if (obs[k] !== 8'(e)) begin errors++; $display("FAIL random_row set%0d pos%0d got %0d exp %0d", s, k, obs[k], e); end
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0] obs [8];
    int e, cycles;
    for (int s = 0; s < 256; s += 2)
      drive4(1'b1, s, $urandom_range(0, 3), 1'b1, s + 1, $urandom_range(0, 3), $urandom_range(0, 3));
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 1000) begin
        @(negedge clk);
        hit = 1'b1; hit_idx = 8'($urandom_range(0, 255)); hit_way = 2'($urandom_range(0, 3));
        fill = 1'b1; fill_idx = 8'($urandom_range(0, 255)); fill_way = 2'($urandom_range(0, 3));
        if (pass == 1 && cycles == 99) flush = 1'b1;
        @(posedge clk); #1;
        hit = 1'b0; fill = 1'b0; flush = 1'b0;
        cycles++;
      end
      exp_q.push_back(pass == 0 ? 256 : 356);
      e = exp_q.pop_front(); checks++;
      if (cycles != e) begin errors++; $display("FAIL flush_busy_cycles pass%0d got %0d exp %0d", pass, cycles, e); end
      for (int s = 0; s < 256; s++) mdl_ident(1'b0, s);
      if (pass == 0) begin
        for (int s = 0; s < 256; s++) begin
          for (int k = 0; k < 4; k++) exp_q.push_back(m4[s][k]);
          read_row(1'b0, s, obs);
          for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); checks++;
            if (obs[k] !== 8'(e)) begin errors++; $display("FAIL flush_row set%0d pos%0d got %0d exp %0d", s, k, obs[k], e); end
          end
        end
      end
    end
  endtask

  task automatic test_ways8();
    logic [7:0] obs [8];
    int e;
    int fw [3] = '{5, 6, 2};
    int fp [3] = '{7, 4, 0};
    for (int i = 0; i < 3; i++) begin
      drive8(1'b0, 0, 0, 1'b1, 0, fw[i], fp[i]);
      @(negedge clk); q_idx8 = 2'd0; valid8 = 8'hFF; #1;
      exp_q.push_back(m8[0][0]);
      e = exp_q.pop_front(); checks++;
      if (victim8 !== 3'(e)) begin errors++; $display("FAIL ways8_victim step%0d got %0d exp %0d", i, victim8, e); end
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(m8[0][k]);
    read_row(1'b1, 0, obs);
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); checks++;
      if (obs[k] !== 8'(e)) begin errors++; $display("FAIL ways8_row pos%0d got %0d exp %0d", k, obs[k], e); end
    end
  endtask

  task automatic test_reset_mid_walk();
    logic [7:0] obs [8];
    int e;
    for (int s = 0; s < 4; s++) drive8(1'b1, s, s, 1'b0, 0, 0, 0);
    @(negedge clk); flush8 = 1'b1;
    @(posedge clk); #1; flush8 = 1'b0;
    @(negedge clk); #2;
    rst8_n = 1'b0; #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midwalk_busy got %0b exp 0", busy8); end
    @(negedge clk); rst8_n = 1'b1;
    for (int s = 0; s < 4; s++) mdl_ident(1'b1, s);
    repeat (2) @(posedge clk); #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midwalk_no_resume got %0b exp 0", busy8); end
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) exp_q.push_back(m8[s][k]);
      read_row(1'b1, s, obs);
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front(); checks++;
        if (obs[k] !== 8'(e)) begin errors++; $display("FAIL midwalk_row set%0d pos%0d got %0d exp %0d", s, k, obs[k], e); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rst8_n = 1'b0;
    flush = 1'b0; hit = 1'b0; fill = 1'b0; hit_idx = 8'd0; fill_idx = 8'd0; q_idx = 8'd0;
    hit_way = 2'd0; fill_way = 2'd0; pred = 2'd0; valid = 4'hF;
    flush8 = 1'b0; hit8 = 1'b0; fill8 = 1'b0; hit_idx8 = 2'd0; fill_idx8 = 2'd0; q_idx8 = 2'd0;
    hit_way8 = 3'd0; fill_way8 = 3'd0; pred8 = 3'd0; valid8 = 8'hFF;
    for (int s = 0; s < 256; s++) mdl_ident(1'b0, s);
    for (int s = 0; s < 4; s++) mdl_ident(1'b1, s);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst8_n = 1'b1;
    test_reset();
    test_hit();
    test_fill();
    test_same_cycle();
    test_valid_mask();
    test_random();
    test_flush();
    test_ways8();
    test_reset_mid_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
